msrv32_store_unit_v2: RTL and testbench
=======================================

Name: msrv32_store_unit_v2

Overview:
- Store-side counterpart of the RV32 load path. Accepts a store from the execute stage: address from the immediate adder, size from funct3, data from rs2.
- Checks alignment and replicates store data across byte lanes, then generates a 4-bit write strobe.
- Drives a single-outstanding AHB-style write (address phase, then data phase) to data memory. Holds the pipeline busy until completion, error or timeout.

Parameters:
TIMEOUT_CYCLES, 16, no-ready cycles tolerated in REQ+WAIT before abort; 0 disables timeout; legal range 0-255

Ports:
ms_riscv32_mp_clk_in  input  1  system clock, rising edge
ms_riscv32_mp_rst_in  input  1  asynchronous, active-low reset
store_req_in  input  1  one-cycle store request from pipeline; sampled only in IDLE
store_size_in  input  2  00 byte, 01 half, 10/11 word
iadder_in  input  32  byte address of store
rs2_in  input  32  store source data
ahb_ready_in  input  1  bus ready (HREADY)
ahb_resp_in  input  1  bus response, 1 = error; valid when ahb_ready_in=1 in WAIT
ms_riscv32_mp_dmwr_req_out  output  1  write address-phase valid
ms_riscv32_mp_dmaddr_out  output  32  word-aligned address {iadder[31:2],2'b00}
ms_riscv32_mp_dmdata_out  output  32  lane-replicated write data
ms_riscv32_mp_dmwr_mask_out  output  4  byte strobes, bit i = byte lane i
su_busy_out  output  1  1 while state != IDLE; pipeline must stall
su_done_out  output  1  one-cycle pulse, store completed OK
su_err_out  output  1  one-cycle pulse, bus error or timeout
su_misaligned_out  output  1  one-cycle pulse, misaligned store rejected

Behaviour:
- Reset (async, rst_in=0): state IDLE, timeout counter 0, all outputs 0 immediately. Reset mid-transaction aborts with no done/err pulse.
- All outputs are registered.
- States: IDLE, REQ (address phase), WAIT (data phase).
- IDLE, store_req_in=1:
  - Misaligned cases: half with addr[0]=1; word with addr[1:0]!=00. Pulse su_misaligned_out next cycle, no bus activity, stay IDLE.
  - Otherwise, at the next edge: register addr, data and mask; set dmwr_req=1; go to REQ; clear counter.
  - Latency is 1 cycle: request in cycle N gives dmwr_req high in cycle N+1.
- Data/mask formatting, with a = iadder[1:0]:
  - byte: data {4{rs2[7:0]}}, mask 0001<<a.
  - half: data {2{rs2[15:0]}}, mask a[1]?1100:0011.
  - word: data rs2, mask 1111.
- REQ: dmwr_req=1; addr/data/mask held stable.
  - ahb_ready_in=1: go WAIT; dmwr_req=0 next cycle.
  - Otherwise stay in REQ and increment the counter.
- WAIT: data/mask held stable.
  - ahb_ready_in=1 and ahb_resp_in=0: su_done_out pulse next cycle; go IDLE.
  - ahb_ready_in=1 and ahb_resp_in=1: su_err_out pulse next cycle; go IDLE.
  - Otherwise increment the counter.
- Timeout (TIMEOUT_CYCLES!=0): when the counter equals TIMEOUT_CYCLES in REQ or WAIT with ready low:
  - go IDLE, dmwr_req=0, su_err_out pulse.
  - The counter does not clear when moving REQ->WAIT; the budget covers the whole transaction.
- On return to IDLE:
  - mask cleared to 0000 and dmwr_req=0.
  - addr/data retain their last values.
- Simultaneous events:
  - store_req_in in the same cycle that WAIT completes is ignored; the pipeline is still stalled by busy.
  - store_req_in in the cycle the done pulse is high is accepted normally: done and the new dmwr_req rise together.
  - store_req_in during REQ/WAIT is ignored; no queueing.
  - ahb_resp_in is ignored outside WAIT.
- su_busy_out is high from the cycle after accept through the last cycle in WAIT. It is low in the cycle the done/err pulse is high.

Test Plan:
- Reset release, then store_req word to 0x0000_1004 with rs2=0xDEADBEEF; ready=1 always:
  - cycle N+1: dmwr_req=1, addr=0x0000_1004, data=0xDEADBEEF, mask=1111.
  - cycle N+2: WAIT with dmwr_req=0.
  - cycle N+3: su_done_out=1, busy=0.
- Byte store to 0x0000_2003 with rs2=0x123456AB: data=0xABABABAB, mask=1000, addr=0x0000_2000. Half store to 0x0000_2002 with rs2=0x0000BEEF: data=0xBEEFBEEF, mask=1100.
- Half store to 0x0000_3001 -> su_misaligned_out=1 for exactly one cycle, dmwr_req never asserts, busy stays 0. Word store to 0x0000_3002 -> same response.
- Word store with ready held low 3 cycles in REQ, then ready=1 with resp=1 in WAIT -> addr/data stable throughout, then su_err_out one-cycle pulse, mask=0000.
- TIMEOUT_CYCLES=4, ready held low forever -> su_err_out pulses after 4 stalled cycles, dmwr_req drops, FSM returns to IDLE and accepts the next store.
- Assert rst_in=0 mid-WAIT -> all outputs 0 asynchronously (before next clock edge), no done/err pulse. After release, a new store completes normally.

Source files
------------

// File: rtl/msrv32_store_unit_v2_if.sv
// Store-unit port bundle: pipeline store request, AHB-style write channel and status pulses.
// The slave modport is the store unit; the master modport is the pipeline/bus side.
interface msrv32_store_unit_v2_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  logic              store_req_in;
  logic [1:0]        store_size_in;
  logic [ADDR_W-1:0] iadder_in;
  logic [DATA_W-1:0] rs2_in;
  logic              ahb_ready_in;
  logic              ahb_resp_in;

  logic              ms_riscv32_mp_dmwr_req_out;
  logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out;
  logic [DATA_W-1:0] ms_riscv32_mp_dmdata_out;
  logic [MASK_W-1:0] ms_riscv32_mp_dmwr_mask_out;
  logic              su_busy_out;
  logic              su_done_out;
  logic              su_err_out;
  logic              su_misaligned_out;

  modport master (
    output store_req_in, store_size_in, iadder_in, rs2_in, ahb_ready_in, ahb_resp_in,
    input  ms_riscv32_mp_dmwr_req_out, ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmdata_out,
           ms_riscv32_mp_dmwr_mask_out, su_busy_out, su_done_out, su_err_out, su_misaligned_out
  );

  modport slave (
    input  store_req_in, store_size_in, iadder_in, rs2_in, ahb_ready_in, ahb_resp_in,
    output ms_riscv32_mp_dmwr_req_out, ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmdata_out,
           ms_riscv32_mp_dmwr_mask_out, su_busy_out, su_done_out, su_err_out, su_misaligned_out
  );
endinterface

// File: rtl/msrv32_store_unit_v2.sv
// RV32 store unit: alignment check, lane replication, strobe generation and a
// single-outstanding address/data-phase write with an optional whole-transaction timeout.
module msrv32_store_unit_v2 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         ms_riscv32_mp_clk_in,
  input  logic                         ms_riscv32_mp_rst_in,
  msrv32_store_unit_v2_if.slave        su_bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam logic             TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wr_beat_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wr_beat_t         beat_q, beat_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             mis_q, mis_d;

  logic [1:0]        lane_c;
  logic [DATA_W-1:0] fmt_data_c;
  logic [MASK_W-1:0] fmt_mask_c;
  logic              misaligned_c;
  logic              timeout_hit_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  assign lane_c = su_bus.iadder_in[1:0];

  // Replicate store data across byte lanes and derive the strobe from size/offset.
  always_comb begin
    fmt_data_c   = su_bus.rs2_in;
    fmt_mask_c   = 4'b1111;
    misaligned_c = 1'b0;
    unique case (su_bus.store_size_in)
      SIZE_BYTE: begin
        fmt_data_c = {4{su_bus.rs2_in[7:0]}};
        fmt_mask_c = 4'b0001 << lane_c;
      end
      SIZE_HALF: begin
        fmt_data_c   = {2{su_bus.rs2_in[15:0]}};
        fmt_mask_c   = lane_c[1] ? 4'b1100 : 4'b0011;
        misaligned_c = lane_c[0];
      end
      default: begin
        misaligned_c = |lane_c;
      end
    endcase
  end

  // Counter saturates so a disabled timeout can never wrap into a false match.
  assign cnt_inc_c     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit_c = TIMEOUT_EN && (cnt_q == TIMEOUT_LIMIT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (su_bus.store_req_in) begin
          if (misaligned_c) begin
            mis_d = 1'b1;
          end else begin
            beat_d.addr = {su_bus.iadder_in[ADDR_W-1:2], 2'b00};
            beat_d.data = fmt_data_c;
            beat_d.mask = fmt_mask_c;
            req_d       = 1'b1;
            cnt_d       = '0;
            state_d     = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (su_bus.ahb_ready_in) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end else if (timeout_hit_c) begin
          req_d       = 1'b0;
          beat_d.mask = '0;
          err_d       = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      S_WAIT: begin
        if (su_bus.ahb_ready_in) begin
          beat_d.mask = '0;
          done_d      = ~su_bus.ahb_resp_in;
          err_d       = su_bus.ahb_resp_in;
          state_d     = S_IDLE;
        end else if (timeout_hit_c) begin
          beat_d.mask = '0;
          err_d       = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      default: begin
        req_d       = 1'b0;
        beat_d.mask = '0;
        state_d     = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign su_bus.ms_riscv32_mp_dmwr_req_out  = req_q;
  assign su_bus.ms_riscv32_mp_dmaddr_out    = beat_q.addr;
  assign su_bus.ms_riscv32_mp_dmdata_out    = beat_q.data;
  assign su_bus.ms_riscv32_mp_dmwr_mask_out = beat_q.mask;
  assign su_bus.su_busy_out                 = busy_q;
  assign su_bus.su_done_out                 = done_q;
  assign su_bus.su_err_out                  = err_q;
  assign su_bus.su_misaligned_out           = mis_q;

endmodule

// File: tb/tb_msrv32_store_unit_v2.sv
// Self-checking bench for msrv32_store_unit_v2: scoreboard of expected write beats
// plus per-scenario cycle checks of handshake, pulses, stall timing and timeout.
module tb_msrv32_store_unit_v2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  msrv32_store_unit_v2_if bus ();

  msrv32_store_unit_v2 #(.TIMEOUT_CYCLES(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .su_bus               (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected beat: lane i carries source byte (i mod n); lane enabled when in the same n-byte group as the address.
  function automatic exp_t model(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] d);
    exp_t e;
    int   n;
    int   a;
    n      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    a      = int'(ad[1:0]);
    e.addr = {ad[31:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      e.data[8*i +: 8] = d[8*(i % n) +: 8];
      e.mask[i]        = ((i / n) == (a / n));
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive a one-cycle store request; returns at the negedge of the cycle after the request.
  task automatic send(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] d, input bit push);
    @(negedge clk);
    bus.store_req_in  = 1'b1;
    bus.store_size_in = sz;
    bus.iadder_in     = ad;
    bus.rs2_in        = d;
    if (push) sb.push_back(model(sz, ad, d));
    @(negedge clk);
    bus.store_req_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [75:0] obs;
    #1 rst_n = 1'b0;
    #2;
    obs = {bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out,
           bus.ms_riscv32_mp_dmwr_mask_out, bus.su_busy_out, bus.su_done_out, bus.su_err_out,
           bus.su_misaligned_out};
    n_cmp++;
    if (obs !== 76'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_basic();
    exp_t e;
    bus.ahb_ready_in = 1'b1;
    bus.ahb_resp_in  = 1'b0;
    send(2'b10, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1);
    n_cmp++;
    if (bus.ms_riscv32_mp_dmwr_req_out !== 1'b1 || bus.su_busy_out !== 1'b1) begin
      n_bad++; $display("FAIL word_req_n1: got req=%b busy=%b want 1/1", bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out} !== {e.addr, e.data, e.mask}) begin
      n_bad++; $display("FAIL word_beat: got %h/%h/%b want %h/%h/%b", bus.ms_riscv32_mp_dmaddr_out,
                        bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out, e.addr, e.data, e.mask);
    end
    tick();
    n_cmp++;
    if (bus.ms_riscv32_mp_dmwr_req_out !== 1'b0 || bus.su_busy_out !== 1'b1 || bus.su_done_out !== 1'b0) begin
      n_bad++; $display("FAIL word_wait_n2: got req=%b busy=%b done=%b want 0/1/0", bus.ms_riscv32_mp_dmwr_req_out,
                        bus.su_busy_out, bus.su_done_out);
    end
    tick();
    n_cmp++;
    if (bus.su_done_out !== 1'b1 || bus.su_busy_out !== 1'b0 || bus.su_err_out !== 1'b0 || bus.ms_riscv32_mp_dmwr_mask_out !== 4'b0000) begin
      n_bad++; $display("FAIL word_done_n3: got done=%b busy=%b err=%b mask=%b want 1/0/0/0000", bus.su_done_out,
                        bus.su_busy_out, bus.su_err_out, bus.ms_riscv32_mp_dmwr_mask_out);
    end
    tick();
    n_cmp++;
    if (bus.su_done_out !== 1'b0) begin n_bad++; $display("FAIL word_done_width: got %b want 0", bus.su_done_out); end
  endtask

  task automatic test_lanes();
    exp_t        e;
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [31:0] d;
    bus.ahb_ready_in = 1'b1;
    bus.ahb_resp_in  = 1'b0;
    send(2'b00, 32'h0000_2003, 32'h1234_56AB, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out} !== {32'h0000_2000, 32'hABAB_ABAB, 4'b1000}) begin
      n_bad++; $display("FAIL byte_lane3: got %h/%h/%b want 00002000/abababab/1000", bus.ms_riscv32_mp_dmaddr_out,
                        bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out);
    end
    tick(); tick(); tick();
    send(2'b01, 32'h0000_2002, 32'h0000_BEEF, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out} !== {32'h0000_2000, 32'hBEEF_BEEF, 4'b1100}) begin
      n_bad++; $display("FAIL half_upper: got %h/%h/%b want 00002000/beefbeef/1100", bus.ms_riscv32_mp_dmaddr_out,
                        bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out);
    end
    tick(); tick(); tick();
    for (int k = 0; k < 8; k++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom();
      d  = $urandom();
      if (sz == 2'b01) ad[0] = 1'b0;
      else if (sz[1]) ad[1:0] = 2'b00;
      send(sz, ad, d, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out} !== {e.addr, e.data, e.mask}) begin
        n_bad++; $display("FAIL rand_beat%0d: got %h/%h/%b want %h/%h/%b", k, bus.ms_riscv32_mp_dmaddr_out,
                          bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out, e.addr, e.data, e.mask);
      end
      tick(); tick();
      n_cmp++;
      if (bus.su_done_out !== 1'b1) begin n_bad++; $display("FAIL rand_done%0d: got %b want 1", k, bus.su_done_out); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2];
    logic [1:0]  sizes [2];
    addrs[0] = 32'h0000_3001; sizes[0] = 2'b01;
    addrs[1] = 32'h0000_3002; sizes[1] = 2'b10;
    bus.ahb_ready_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send(sizes[k], addrs[k], 32'h5555_AAAA, 1'b0);
      n_cmp++;
      if ({bus.su_misaligned_out, bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out} !== 3'b100) begin
        n_bad++; $display("FAIL misalign_pulse%0d: got mis/req/busy=%b want 100", k,
                          {bus.su_misaligned_out, bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out});
      end
      tick();
      n_cmp++;
      if ({bus.su_misaligned_out, bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out} !== 3'b000) begin
        n_bad++; $display("FAIL misalign_after%0d: got mis/req/busy=%b want 000", k,
                          {bus.su_misaligned_out, bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out});
      end
    end
  endtask

  task automatic test_stall_err();
    exp_t e;
    bus.ahb_ready_in = 1'b0;
    bus.ahb_resp_in  = 1'b0;
    send(2'b10, 32'h0000_4000, 32'hCAFE_F00D, 1'b1);
    e = sb.pop_front();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin bus.ahb_ready_in = 1'b1; bus.ahb_resp_in = 1'b1; end
      n_cmp++;
      if ({bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out} !== {1'b1, e.addr, e.data, e.mask}) begin
        n_bad++; $display("FAIL stall_hold%0d: got %b/%h/%h/%b want 1/%h/%h/%b", c, bus.ms_riscv32_mp_dmwr_req_out,
                          bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out,
                          e.addr, e.data, e.mask);
      end
      tick();
    end
    n_cmp++;
    if ({bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out, bus.ms_riscv32_mp_dmdata_out} !== {1'b0, 1'b1, e.data}) begin
      n_bad++; $display("FAIL stall_wait: got req=%b busy=%b data=%h want 0/1/%h", bus.ms_riscv32_mp_dmwr_req_out,
                        bus.su_busy_out, bus.ms_riscv32_mp_dmdata_out, e.data);
    end
    tick();
    n_cmp++;
    if ({bus.su_err_out, bus.su_done_out, bus.su_busy_out, bus.ms_riscv32_mp_dmwr_mask_out} !== 7'b1000000) begin
      n_bad++; $display("FAIL bus_err: got err/done/busy/mask=%b want 1000000",
                        {bus.su_err_out, bus.su_done_out, bus.su_busy_out, bus.ms_riscv32_mp_dmwr_mask_out});
    end
    n_cmp++;
    if (bus.ms_riscv32_mp_dmaddr_out !== e.addr) begin
      n_bad++; $display("FAIL addr_retained: got %h want %h", bus.ms_riscv32_mp_dmaddr_out, e.addr);
    end
    bus.ahb_resp_in = 1'b0;
    tick();
    n_cmp++;
    if (bus.su_err_out !== 1'b0) begin n_bad++; $display("FAIL err_width: got %b want 0", bus.su_err_out); end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   hi;
    bit   seen;
    bus.ahb_ready_in = 1'b0;
    send(2'b01, 32'h0000_5006, 32'h0000_7788, 1'b1);
    e    = sb.pop_front();
    hi   = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.su_err_out === 1'b1) seen = 1'b1;
      else begin
        if (bus.ms_riscv32_mp_dmwr_req_out === 1'b1) hi++;
        tick();
      end
    end
    n_cmp++;
    if (!seen || hi != 5) begin n_bad++; $display("FAIL timeout_req_cycles: got seen=%0d cycles=%0d want 1/5", seen, hi); end
    n_cmp++;
    if ({bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out, bus.ms_riscv32_mp_dmwr_mask_out} !== 6'b000000) begin
      n_bad++; $display("FAIL timeout_idle: got req/busy/mask=%b want 000000",
                        {bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out, bus.ms_riscv32_mp_dmwr_mask_out});
    end
    bus.ahb_ready_in = 1'b1;
    send(2'b10, 32'h0000_5008, 32'h0BAD_CAFE, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmdata_out} !== {1'b1, e.data}) begin
      n_bad++; $display("FAIL timeout_next_accept: got req=%b data=%h want 1/%h", bus.ms_riscv32_mp_dmwr_req_out,
                        bus.ms_riscv32_mp_dmdata_out, e.data);
    end
    tick(); tick();
    n_cmp++;
    if (bus.su_done_out !== 1'b1) begin n_bad++; $display("FAIL timeout_next_done: got %b want 1", bus.su_done_out); end
  endtask

  task automatic test_budget_span();
    int w;
    bit seen;
    bus.ahb_ready_in = 1'b0;
    send(2'b00, 32'h0000_6001, 32'h0000_0042, 1'b1);
    void'(sb.pop_front());
    tick(); tick();
    bus.ahb_ready_in = 1'b1;
    tick();
    bus.ahb_ready_in = 1'b0;
    w    = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.su_err_out === 1'b1) seen = 1'b1;
      else begin
        if (bus.su_busy_out === 1'b1 && bus.ms_riscv32_mp_dmwr_req_out === 1'b0) w++;
        tick();
      end
    end
    n_cmp++;
    if (!seen || w != 3) begin n_bad++; $display("FAIL budget_span_wait_cycles: got seen=%0d cycles=%0d want 1/3", seen, w); end
    bus.ahb_ready_in = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bus.ahb_ready_in = 1'b1;
    bus.ahb_resp_in  = 1'b1;
    send(2'b10, 32'h0000_7000, 32'h1111_2222, 1'b1);
    void'(sb.pop_front());
    bus.store_req_in = 1'b1; bus.store_size_in = 2'b10; bus.iadder_in = 32'h0000_7F00; bus.rs2_in = 32'hFFFF_0000;
    tick();
    bus.ahb_resp_in = 1'b0;
    tick();
    n_cmp++;
    if ({bus.su_done_out, bus.su_err_out, bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out} !== 4'b1000) begin
      n_bad++; $display("FAIL b2b_ignored: got done/err/req/busy=%b want 1000",
                        {bus.su_done_out, bus.su_err_out, bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out});
    end
    bus.store_size_in = 2'b00; bus.iadder_in = 32'h0000_7101; bus.rs2_in = 32'h0000_00C3;
    sb.push_back(model(2'b00, 32'h0000_7101, 32'h0000_00C3));
    tick();
    bus.store_req_in = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out} !== {1'b1, e.addr, e.data, e.mask}) begin
      n_bad++; $display("FAIL b2b_accept: got %b/%h/%h/%b want 1/%h/%h/%b", bus.ms_riscv32_mp_dmwr_req_out,
                        bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out,
                        e.addr, e.data, e.mask);
    end
    tick(); tick();
    n_cmp++;
    if (bus.su_done_out !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", bus.su_done_out); end
  endtask

  task automatic test_reset_mid();
    logic [75:0] obs;
    exp_t        e;
    bus.ahb_ready_in = 1'b1;
    bus.ahb_resp_in  = 1'b0;
    send(2'b10, 32'h0000_8000, 32'hA5A5_5A5A, 1'b1);
    void'(sb.pop_front());
    tick();
    bus.ahb_ready_in = 1'b0;
    n_cmp++;
    if ({bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out} !== 2'b01) begin
      n_bad++; $display("FAIL rstmid_in_wait: got req/busy=%b want 01", {bus.ms_riscv32_mp_dmwr_req_out, bus.su_busy_out});
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out,
           bus.ms_riscv32_mp_dmwr_mask_out, bus.su_busy_out, bus.su_done_out, bus.su_err_out,
           bus.su_misaligned_out};
    n_cmp++;
    if (obs !== 76'd0) begin n_bad++; $display("FAIL rstmid_async_clear: got %h want 0", obs); end
    bus.ahb_ready_in = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({bus.su_done_out, bus.su_err_out} !== 2'b00) begin
      n_bad++; $display("FAIL rstmid_no_pulse: got done/err=%b want 00", {bus.su_done_out, bus.su_err_out});
    end
    send(2'b01, 32'h0000_8002, 32'h0000_1357, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out} !== {1'b1, e.data, e.mask}) begin
      n_bad++; $display("FAIL rstmid_new_store: got %b/%h/%b want 1/%h/%b", bus.ms_riscv32_mp_dmwr_req_out,
                        bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out, e.data, e.mask);
    end
    tick(); tick();
    n_cmp++;
    if (bus.su_done_out !== 1'b1) begin n_bad++; $display("FAIL rstmid_new_done: got %b want 1", bus.su_done_out); end
  endtask

  initial begin
    bus.store_req_in  = 1'b0;
    bus.store_size_in = 2'b00;
    bus.iadder_in     = '0;
    bus.rs2_in        = '0;
    bus.ahb_ready_in  = 1'b1;
    bus.ahb_resp_in   = 1'b0;
    test_reset();
    test_word_basic();
    test_lanes();
    test_misaligned();
    test_stall_err();
    test_timeout();
    test_budget_span();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
